// File: rtl/jtcop_sndcmd.sv
// Sound command transmitter: buffers main-CPU command bytes and hands them one at a
// time to the sound CPU through a latch plus an snreq pulse, waiting for ack or timeout.
module jtcop_sndcmd #(
   parameter int AW      = 2,
   parameter int REQ_LEN = 4,
   parameter int TOUT_W  = 16
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       cpu_we,
   input  logic [7:0] cpu_din,
   input  logic       cpu_rd,
   output logic [7:0] status,
   output logic [7:0] latch,
   output logic       snreq,
   input  logic       snd_ack,
   output logic       tout,
   output logic [1:0] dbg_state
);

   // Handshake: a push is a rising edge of cpu_we, an ack is a rising edge of snd_ack.
   // snreq is held high for REQ_LEN cycles per byte, then the byte waits for ack or timeout.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   localparam int DEPTH = 2**AW;

   logic [7:0]        r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic              r_ovf;
   logic              r_we_l;
   logic              r_rd_l;
   logic              r_ack_l;
   logic              r_ack_seen;
   logic              r_snreq;
   logic              r_tout;
   logic [7:0]        r_latch;
   logic [7:0]        r_rcnt;
   logic [TOUT_W-1:0] r_timer;
   state_t            r_state;
   state_t            w_next;

   logic              w_push_ev;
   logic              w_rd_ev;
   logic              w_ack_ev;
   logic              w_full;
   logic              w_empty;
   logic              w_push_ok;
   logic              w_pop;
   logic              w_wait_ack;
   logic              w_timeout;
   logic              w_busy;
   logic [2:0]        w_cnt3;

   assign w_push_ev = cpu_we  & ~r_we_l;
   assign w_rd_ev   = cpu_rd  & ~r_rd_l;
   assign w_ack_ev  = snd_ack & ~r_ack_l;
   assign w_full    = (r_count == (AW+1)'(DEPTH));
   assign w_empty   = (r_count == '0);
   // Fullness is judged before this edge's pop, so a push at full is dropped.
   assign w_push_ok = w_push_ev & ~w_full;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (!w_empty) w_next = ST_REQ;
         ST_REQ:  if (r_rcnt == 8'd0) w_next = ST_WAIT;
         ST_WAIT: if (r_ack_seen || w_ack_ev || (&r_timer)) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      w_pop      = 1'b0;
      w_wait_ack = 1'b0;
      w_timeout  = 1'b0;
      w_busy     = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            w_pop  = ~w_empty;
         end
         ST_WAIT: begin
            w_wait_ack = r_ack_seen | w_ack_ev;
            w_timeout  = ~(r_ack_seen | w_ack_ev) & (&r_timer);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst && w_push_ok) r_mem[r_wr_ptr] <= cpu_din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_ovf      <= 1'b0;
         r_we_l     <= 1'b0;
         r_rd_l     <= 1'b0;
         r_ack_l    <= 1'b0;
         r_ack_seen <= 1'b0;
         r_snreq    <= 1'b0;
         r_tout     <= 1'b0;
         r_latch    <= 8'h00;
         r_rcnt     <= 8'd0;
         r_timer    <= '0;
      end else begin
         r_we_l  <= cpu_we;
         r_rd_l  <= cpu_rd;
         r_ack_l <= snd_ack;
         r_tout  <= w_timeout;
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop);
         // An overflow on the same edge as a status read keeps ovf set.
         if (w_push_ev && w_full) r_ovf <= 1'b1;
         else if (w_rd_ev)        r_ovf <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_latch    <= r_mem[r_rd_ptr];
                  r_snreq    <= 1'b1;
                  r_rcnt     <= 8'(REQ_LEN - 1);
                  r_ack_seen <= 1'b0;
               end
            end
            ST_REQ: begin
               if (w_ack_ev) r_ack_seen <= 1'b1;
               if (r_rcnt == 8'd0) begin
                  r_snreq <= 1'b0;
                  r_timer <= '0;
               end else begin
                  r_rcnt <= r_rcnt - 8'd1;
               end
            end
            ST_WAIT: begin
               if (!w_wait_ack && !w_timeout) r_timer <= r_timer + TOUT_W'(1);
            end
            default: ;
         endcase
      end
   end

   generate
      if (AW >= 3) begin : g_sat
         assign w_cnt3 = (r_count > (AW+1)'(7)) ? 3'd7 : r_count[2:0];
      end else begin : g_nosat
         assign w_cnt3 = 3'(r_count);
      end
   endgenerate

   assign status    = {w_full, w_empty, r_ovf, w_busy, 1'b0, w_cnt3};
   assign latch     = r_latch;
   assign snreq     = r_snreq;
   assign tout      = r_tout;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_jtcop_sndcmd.sv
// Directed bench for jtcop_sndcmd: a default instance and a short-timeout instance
// share the same stimulus; expected values are hand-computed per step.
module tb_jtcop_sndcmd;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cpu_we = 1'b0;
   logic       cpu_rd = 1'b0;
   logic       snd_ack = 1'b0;
   logic [7:0] cpu_din = 8'h00;

   logic [7:0] status, latch, status_t, latch_t;
   logic       snreq, tout, snreq_t, tout_t;
   logic [1:0] dbg, dbg_t;

   int   n_cmp = 0;
   int   n_err = 0;
   int   rises = 0;
   int   r0;
   logic snreq_prev = 1'b0;

   always #5 clk = ~clk;

   jtcop_sndcmd u_dut (
      .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_din(cpu_din), .cpu_rd(cpu_rd),
      .status(status), .latch(latch), .snreq(snreq), .snd_ack(snd_ack),
      .tout(tout), .dbg_state(dbg)
   );

   jtcop_sndcmd #(.TOUT_W(4)) u_dut_t (
      .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_din(cpu_din), .cpu_rd(cpu_rd),
      .status(status_t), .latch(latch_t), .snreq(snreq_t), .snd_ack(snd_ack),
      .tout(tout_t), .dbg_state(dbg_t)
   );

   always @(negedge clk) begin
      if (snreq && !snreq_prev) rises <= rises + 1;
      snreq_prev <= snreq;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pulse_we(input logic [7:0] b);
      cpu_din = b;
      cpu_we  = 1'b1;
      tick();
      cpu_we  = 1'b0;
      tick();
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      run(2);
      chk("rst_status", status, 8'h40);
      chk("rst_latch", latch, 8'h00);
      chk("rst_snreq", {7'b0, snreq}, 8'h00);
      chk("rst_tout", {7'b0, tout}, 8'h00);
      chk("rst_state", {6'b0, dbg}, 8'h00);
      rst = 1'b0;
      tick();

      // Single command with a long write strobe
      cpu_din = 8'h5A;
      cpu_we  = 1'b1;
      tick();
      chk("s1_push_status", status, 8'h01);
      chk("s1_push_snreq", {7'b0, snreq}, 8'h00);
      tick();
      chk("s1_latch", latch, 8'h5A);
      chk("s1_snreq_rise", {7'b0, snreq}, 8'h01);
      chk("s1_load_status", status, 8'h50);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("s1_snreq_hold", {7'b0, snreq}, 8'h01);
      end
      tick();
      chk("s1_snreq_fall", {7'b0, snreq}, 8'h00);
      chk("s1_wait_state", {6'b0, dbg}, 8'h02);
      run(4);
      cpu_we = 1'b0;
      chk("s1_one_push", status, 8'h50);
      run(10);
      snd_ack = 1'b1;
      tick();
      chk("s1_ack_idle", status, 8'h40);
      chk("s1_latch_held", latch, 8'h5A);
      run(2);
      snd_ack = 1'b0;
      tick();
      chk("s1_final_latch", latch, 8'h5A);
      chk("s1_tout", {7'b0, tout}, 8'h00);

      // Back-to-back commands
      r0 = rises;
      pulse_we(8'h01);
      chk("b2b_latch1", latch, 8'h01);
      pulse_we(8'h02);
      cpu_din = 8'h03;
      cpu_we  = 1'b1;
      tick();
      chk("b2b_count2", status, 8'h12);
      chk("b2b_latch1_hold", latch, 8'h01);
      cpu_we = 1'b0;
      tick();
      chk("b2b_wait1", {7'b0, snreq}, 8'h00);
      snd_ack = 1'b1;
      tick();
      chk("b2b_ack1_latch", latch, 8'h01);
      chk("b2b_ack1_status", status, 8'h02);
      tick();
      chk("b2b_latch2", latch, 8'h02);
      chk("b2b_snreq2", {7'b0, snreq}, 8'h01);
      chk("b2b_count1", status, 8'h11);
      snd_ack = 1'b0;
      run(4);
      chk("b2b_wait2", {7'b0, snreq}, 8'h00);
      chk("b2b_latch2_hold", latch, 8'h02);
      snd_ack = 1'b1;
      tick();
      snd_ack = 1'b0;
      tick();
      chk("b2b_latch3", latch, 8'h03);
      chk("b2b_snreq3", {7'b0, snreq}, 8'h01);
      run(4);
      snd_ack = 1'b1;
      tick();
      snd_ack = 1'b0;
      tick();
      chk("b2b_done", status, 8'h40);
      chk("b2b_rises", 8'(rises - r0), 8'd3);

      // Overflow, sticky flag, clear by status read, ordered drain
      pulse_we(8'h11);
      chk("ovf_latch_first", latch, 8'h11);
      for (int i = 0; i < 5; i++) pulse_we(8'h12 + 8'(i));
      chk("ovf_status_full", status, 8'hB4);
      chk("ovf_latch_held", latch, 8'h11);
      cpu_rd = 1'b1;
      tick();
      chk("ovf_cleared", status, 8'h94);
      tick();
      cpu_rd = 1'b0;
      tick();
      chk("ovf_stays_clear", status, 8'h94);
      for (int i = 0; i < 4; i++) begin
         snd_ack = 1'b1;
         tick();
         snd_ack = 1'b0;
         tick();
         chk("ovf_drain_latch", latch, 8'h12 + 8'(i));
         chk("ovf_drain_status", status, {1'b0, (i == 3), 1'b0, 1'b1, 1'b0, 3'(3 - i)});
         run(4);
      end
      snd_ack = 1'b1;
      tick();
      snd_ack = 1'b0;
      tick();
      chk("ovf_drained", status, 8'h40);

      // Ack arriving during REQ
      pulse_we(8'h77);
      snd_ack = 1'b1;
      tick();
      snd_ack = 1'b0;
      run(3);
      chk("areq_wait", {6'b0, dbg}, 8'h02);
      chk("areq_snreq_low", {7'b0, snreq}, 8'h00);
      tick();
      chk("areq_exit", status, 8'h40);
      chk("areq_no_tout", {7'b0, tout}, 8'h00);
      chk("areq_latch", latch, 8'h77);

      // Timeout on the short-timer instance
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      tick();
      pulse_we(8'hA1);
      pulse_we(8'hA2);
      pulse_we(8'hA3);
      pulse_we(8'hA4);
      chk("to_count3", status_t, 8'h13);
      chk("to_wait", {6'b0, dbg_t}, 8'h02);
      run(13);
      chk("to_not_yet", {7'b0, tout_t}, 8'h00);
      chk("to_still_wait", {6'b0, dbg_t}, 8'h02);
      tick();
      chk("to_pulse", {7'b0, tout_t}, 8'h01);
      chk("to_idle_status", status_t, 8'h03);
      chk("to_latch_held", latch_t, 8'hA1);
      cpu_din = 8'hA5;
      cpu_we  = 1'b1;
      tick();
      chk("to_pulse_end", {7'b0, tout_t}, 8'h00);
      chk("to_next_latch", latch_t, 8'hA2);
      chk("to_next_snreq", {7'b0, snreq_t}, 8'h01);
      chk("to_push_pop_cnt", status_t, 8'h13);
      cpu_we = 1'b0;
      tick();
      pulse_we(8'hA6);
      chk("to_full", status_t, 8'h94);
      run(16);
      chk("to2_not_yet", {7'b0, tout_t}, 8'h00);
      tick();
      chk("to2_pulse", {7'b0, tout_t}, 8'h01);
      cpu_din = 8'hA7;
      cpu_we  = 1'b1;
      tick();
      chk("to2_latch", latch_t, 8'hA3);
      chk("to2_drop_at_full", status_t, 8'h33);
      cpu_we = 1'b0;
      tick();

      // Reset in WAIT with bytes queued
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      tick();
      pulse_we(8'hB1);
      pulse_we(8'hB2);
      pulse_we(8'hB3);
      run(2);
      chk("mr_queued", status, 8'h12);
      chk("mr_latch", latch, 8'hB1);
      rst = 1'b1;
      tick();
      chk("mr_snreq", {7'b0, snreq}, 8'h00);
      chk("mr_latch_clr", latch, 8'h00);
      chk("mr_status", status, 8'h40);
      chk("mr_tout", {7'b0, tout}, 8'h00);
      chk("mr_state", {6'b0, dbg}, 8'h00);
      rst = 1'b0;
      tick();
      chk("mr_after", status, 8'h40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
